// File: rtl/uart_cmd_queue_if.sv
// Word path between the UART receive top, the command queue and the SCCB master.
// Upstream pulse-valid words in, downstream valid/ready register commands out.
interface uart_cmd_queue_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;

    modport slave (
        input  in_data, in_valid, cmd_ready,
        output cmd_valid, cmd_addr, cmd_data
    );

    modport master (
        output in_data, in_valid, cmd_ready,
        input  cmd_valid, cmd_addr, cmd_data
    );
endinterface

// File: rtl/uart_cmd_queue.sv
// Queue of UART-assembled {addr,data} words feeding the SCCB register writer.
// DEPTH-1 word circular RAM plus the output register, with flush and overflow.
module uart_cmd_queue #(
    parameter int          DEPTH      = 8,
    parameter bit          FLUSH_EN   = 1'b1,
    parameter logic [15:0] FLUSH_CODE = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_cmd_queue_if.slave            bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam int SLOTS = DEPTH - 1;

    logic [15:0]   ram [SLOTS];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] ram_cnt;
    logic          flush;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic          direct;
    logic          ram_wr;
    logic          ram_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        flush   = FLUSH_EN && bus.in_valid && (bus.in_data == FLUSH_CODE);
        push    = bus.in_valid && !flush;
        pop     = bus.cmd_valid && bus.cmd_ready;
        full    = (level == LW'(DEPTH));
        ram_cnt = level - LW'(bus.cmd_valid);
        accept  = push && (!full || pop);
        // Word bypasses RAM when the output register is (or becomes) free
        // and nothing older is waiting in RAM.
        direct  = accept && (!bus.cmd_valid || (pop && ram_cnt == '0));
        ram_wr  = accept && !direct;
        ram_rd  = pop && (ram_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && ram_wr)
            ram[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cmd_valid <= 1'b0;
            bus.cmd_addr  <= '0;
            bus.cmd_data  <= '0;
            level         <= '0;
            overflow      <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
        end else begin
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            if (flush) begin
                bus.cmd_valid <= 1'b0;
                level         <= '0;
                rd_ptr        <= '0;
                wr_ptr        <= '0;
            end else begin
                if (ram_rd) begin
                    {bus.cmd_addr, bus.cmd_data} <= ram[rd_ptr];
                    rd_ptr <= nxt(rd_ptr);
                end else if (direct) begin
                    {bus.cmd_addr, bus.cmd_data} <= bus.in_data;
                    bus.cmd_valid <= 1'b1;
                end else if (pop) begin
                    bus.cmd_valid <= 1'b0;
                end

                if (ram_wr)
                    wr_ptr <= nxt(wr_ptr);

                if (accept && !pop)
                    level <= level + 1'b1;
                else if (pop && !accept)
                    level <= level - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_queue.sv
// Directed bench for uart_cmd_queue: fill, overflow, drain order,
// full push+pop, flush and reset-with-push.
module tb_uart_cmd_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] level;
    logic       overflow;
    logic       ovf_clr;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_cmd_queue_if bus ();

    uart_cmd_queue dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are read 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        ovf_clr       = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.cmd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("rst_valid", 32'(bus.cmd_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_addr", 32'(bus.cmd_addr), 0);
        chk("rst_data", 32'(bus.cmd_data), 0);

        push(16'h1280);
        chk("t2_valid", 32'(bus.cmd_valid), 1);
        chk("t2_addr", 32'(bus.cmd_addr), 32'h12);
        chk("t2_data", 32'(bus.cmd_data), 32'h80);
        chk("t2_level", 32'(level), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold", {15'd0, bus.cmd_valid, bus.cmd_addr, bus.cmd_data},
                32'h1_1280);
        end
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        chk("t2_pop_valid", 32'(bus.cmd_valid), 0);
        chk("t2_pop_level", 32'(level), 0);

        for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
        chk("t3_full", 32'(level), 8);
        chk("t3_noovf", 32'(overflow), 0);
        push(16'h0108);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_level", 32'(level), 8);
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_v", 32'(bus.cmd_valid), 1);
            chk("t3_drain_w", {16'd0, bus.cmd_addr, bus.cmd_data},
                32'h0100 + 32'(i));
            step();
        end
        bus.cmd_ready = 1'b0;
        chk("t3_empty_v", 32'(bus.cmd_valid), 0);
        chk("t3_empty_l", 32'(level), 0);
        chk("t3_ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 0);

        for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i));
        chk("t4_full", 32'(level), 8);
        bus.cmd_ready = 1'b1;
        push(16'h0AAA);
        chk("t4_level", 32'(level), 8);
        chk("t4_ovf", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain_v", 32'(bus.cmd_valid), 1);
            chk("t4_drain_w", {16'd0, bus.cmd_addr, bus.cmd_data},
                (i == 7) ? 32'h0AAA : 32'h0201 + 32'(i));
            step();
        end
        bus.cmd_ready = 1'b0;
        chk("t4_empty", 32'(bus.cmd_valid), 0);

        for (int i = 0; i < 3; i++) push(16'h0300 + 16'(i));
        chk("t5_level3", 32'(level), 3);
        push(16'hFFFF);
        chk("t5_flush_l", 32'(level), 0);
        chk("t5_flush_v", 32'(bus.cmd_valid), 0);
        chk("t5_flush_ovf", 32'(overflow), 0);
        push(16'h3344);
        chk("t5_valid", 32'(bus.cmd_valid), 1);
        chk("t5_addr", 32'(bus.cmd_addr), 32'h33);
        chk("t5_data", 32'(bus.cmd_data), 32'h44);
        chk("t5_level", 32'(level), 1);

        for (int i = 0; i < 3; i++) push(16'h0400 + 16'(i));
        chk("t6_level4", 32'(level), 4);
        rst          = 1'b1;
        bus.in_data  = 16'h0555;
        bus.in_valid = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("t6_valid", 32'(bus.cmd_valid), 0);
        chk("t6_level", 32'(level), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_addr", 32'(bus.cmd_addr), 0);
        chk("t6_data", 32'(bus.cmd_data), 0);
        repeat (3) step();
        chk("t6_idle_l", 32'(level), 0);
        chk("t6_idle_v", 32'(bus.cmd_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
